sr_flag_bank: RTL and testbench

//  Parametrised bank of CHANNELS clocked set/reset flags. Replaces standalone SR latches for

---
 rtl/sr_flag_bank.sv | 147 ++++++++++++++
 tb/tb_sr_flag_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - bank of clocked set/reset status flags with sync, edge qualify and IRQ
// Each channel: optional input synchroniser, optional rising-edge qualify, S/R update, change pulses.
module sr_flag_bank #(
   parameter int unsigned         CHANNELS    = 4,
   parameter int unsigned         SYNC_STAGES = 2,
   parameter int unsigned         MODE        = 0,
   parameter int unsigned         EDGE_MODE   = 0,
   parameter logic [CHANNELS-1:0] INIT        = '0,
   localparam int unsigned        CW          = $clog2(CHANNELS + 1)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] S,
   input  logic [CHANNELS-1:0] R,
   input  logic [CHANNELS-1:0] IRQ_MASK,
   input  logic [CHANNELS-1:0] IRQ_ACK,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] Q_RISE,
   output logic [CHANNELS-1:0] Q_FALL,
   output logic [CW-1:0]       CNT,
   output logic [CHANNELS-1:0] PENDING,
   output logic                IRQ
);

   logic [CHANNELS-1:0] s_sync, r_sync;
   logic [CHANNELS-1:0] s_eff, r_eff;
   logic [CHANNELS-1:0] q_q, q_d;
   logic [CHANNELS-1:0] q_prev_q, q_prev_d;
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] q_rise, q_fall;

   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign s_sync = S;
         assign r_sync = R;
      end else begin : g_sync
         logic [CHANNELS-1:0] s_pipe_q [SYNC_STAGES];
         logic [CHANNELS-1:0] s_pipe_d [SYNC_STAGES];
         logic [CHANNELS-1:0] r_pipe_q [SYNC_STAGES];
         logic [CHANNELS-1:0] r_pipe_d [SYNC_STAGES];

         always_comb begin
            s_pipe_d[0] = S;
            r_pipe_d[0] = R;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
               s_pipe_d[i] = s_pipe_q[i-1];
               r_pipe_d[i] = r_pipe_q[i-1];
            end
         end

         // Reset flushes the chain so a pulse in flight never lands after release.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                  s_pipe_q[i] <= '0;
                  r_pipe_q[i] <= '0;
               end
            end else begin
               s_pipe_q <= s_pipe_d;
               r_pipe_q <= r_pipe_d;
            end
         end

         assign s_sync = s_pipe_q[SYNC_STAGES-1];
         assign r_sync = r_pipe_q[SYNC_STAGES-1];
      end

      if (EDGE_MODE != 0) begin : g_edge
         logic [CHANNELS-1:0] s_last_q, s_last_d;
         logic [CHANNELS-1:0] r_last_q, r_last_d;

         always_comb begin
            s_last_d = s_sync;
            r_last_d = r_sync;
         end

         // Cleared on reset so an input already high at release counts as one edge.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               s_last_q <= '0;
               r_last_q <= '0;
            end else begin
               s_last_q <= s_last_d;
               r_last_q <= r_last_d;
            end
         end

         assign s_eff = s_sync & ~s_last_q;
         assign r_eff = r_sync & ~r_last_q;
      end else begin : g_level
         assign s_eff = s_sync;
         assign r_eff = r_sync;
      end
   endgenerate

   assign q_rise = q_q & ~q_prev_q;
   assign q_fall = ~q_q & q_prev_q;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         case ({s_eff[i], r_eff[i]})
            2'b10: q_d[i] = 1'b1;
            2'b01: q_d[i] = 1'b0;
            2'b11: begin
               if (MODE == 0) begin
                  q_d[i] = 1'b0;
               end else if (MODE == 1) begin
                  q_d[i] = 1'b1;
               end else if (MODE == 2) begin
                  q_d[i] = ~q_q[i];
               end
            end
            default: ;
         endcase
      end
      q_prev_d  = q_q;
      // A fresh masked rise beats a same-cycle acknowledge.
      pending_d = (q_rise & IRQ_MASK) | (pending_q & ~IRQ_ACK);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_q       <= INIT;
         q_prev_q  <= INIT;
         pending_q <= '0;
      end else begin
         q_q       <= q_d;
         q_prev_q  <= q_prev_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      CNT = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         CNT = CNT + CW'(q_q[i]);
      end
   end

   assign Q       = q_q;
   assign Q_RISE  = q_rise;
   assign Q_FALL  = q_fall;
   assign PENDING = pending_q;
   assign IRQ     = |pending_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb/tb_sr_flag_bank.sv - self-checking bench for sr_flag_bank over eight parameter sets
// Inputs are shared by all instances; a history-based model predicts each instance.
module tb_sr_flag_bank;

   localparam int N = 8;
   localparam int         P_SYNC [N] = '{2, 2, 2, 2, 2, 0, 1, 3};
   localparam int         P_MODE [N] = '{0, 1, 2, 3, 0, 0, 2, 1};
   localparam int         P_EDGE [N] = '{0, 0, 0, 0, 1, 0, 1, 0};
   localparam logic [3:0] P_INIT [N] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                         4'b0000, 4'b0101, 4'b0101, 4'b0000};

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] S = '0, R = '0, IRQ_MASK = '0, IRQ_ACK = '0;

   logic [3:0] q_o [N];
   logic [3:0] rise_o [N];
   logic [3:0] fall_o [N];
   logic [3:0] pend_o [N];
   logic [2:0] cnt_o [N];
   logic       irq_o [N];

   int total = 0;
   int bad   = 0;

   logic [3:0] hs[$];
   logic [3:0] hr[$];
   logic [3:0] mq [N];
   logic [3:0] mprev [N];
   logic [3:0] mpend [N];

   always #5 CLK = ~CLK;

   for (genvar k = 0; k < N; k++) begin : g_dut
      sr_flag_bank #(
         .CHANNELS(4), .SYNC_STAGES(P_SYNC[k]), .MODE(P_MODE[k]),
         .EDGE_MODE(P_EDGE[k]), .INIT(P_INIT[k])
      ) u_dut (
         .CLK(CLK), .RST(RST), .S(S), .R(R), .IRQ_MASK(IRQ_MASK), .IRQ_ACK(IRQ_ACK),
         .Q(q_o[k]), .Q_RISE(rise_o[k]), .Q_FALL(fall_o[k]), .CNT(cnt_o[k]),
         .PENDING(pend_o[k]), .IRQ(irq_o[k])
      );
   end

   // Input sampled at post-reset edge idx (1-based); zero before the first edge.
   function automatic logic [3:0] hist(input bit sel_r, input int idx);
      if (idx < 1) return 4'b0000;
      return sel_r ? hr[idx-1] : hs[idx-1];
   endfunction

   task automatic model_reset();
      hs.delete();
      hr.delete();
      for (int k = 0; k < N; k++) begin
         mq[k]    = P_INIT[k];
         mprev[k] = P_INIT[k];
         mpend[k] = 4'b0000;
      end
   endtask

   // Edge m acts on the input sampled SYNC_STAGES edges earlier.
   task automatic model_edge();
      int         m, j;
      logic [3:0] sn, sp, rn, rp, se, re, rise, nq;
      hs.push_back(S);
      hr.push_back(R);
      m = hs.size();
      for (int k = 0; k < N; k++) begin
         j  = m - P_SYNC[k];
         sn = hist(1'b0, j);
         sp = hist(1'b0, j - 1);
         rn = hist(1'b1, j);
         rp = hist(1'b1, j - 1);
         se = (P_EDGE[k] != 0) ? (sn & ~sp) : sn;
         re = (P_EDGE[k] != 0) ? (rn & ~rp) : rn;
         rise = mq[k] & ~mprev[k];
         nq = mq[k];
         for (int b = 0; b < 4; b++) begin
            if (se[b] && !re[b]) nq[b] = 1'b1;
            else if (!se[b] && re[b]) nq[b] = 1'b0;
            else if (se[b] && re[b]) begin
               if (P_MODE[k] == 0) nq[b] = 1'b0;
               else if (P_MODE[k] == 1) nq[b] = 1'b1;
               else if (P_MODE[k] == 2) nq[b] = ~mq[k][b];
            end
         end
         mpend[k] = (rise & IRQ_MASK) | (mpend[k] & ~IRQ_ACK);
         mprev[k] = mq[k];
         mq[k]    = nq;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (!RST) model_edge();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      S = '0; R = '0; IRQ_ACK = '0; IRQ_MASK = '0;
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      IRQ_MASK = 4'b0011; S = 4'b1011;
      tick();
      S = '0;
      repeat (3) tick();
      total++; if (q_o[0] !== 4'b1011) begin bad++; $display("FAIL pre_reset_q got=%b exp=1011", q_o[0]); end
      total++; if (pend_o[0] !== 4'b0011) begin bad++; $display("FAIL pre_reset_pend got=%b exp=0011", pend_o[0]); end
      RST = 1'b1;
      model_reset();
      #1;
      total++; if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b exp=0000", q_o[0]); end
      total++; if (pend_o[0] !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b exp=0000", pend_o[0]); end
      total++; if (irq_o[0] !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o[0]); end
      total++; if (cnt_o[0] !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o[0]); end
      total++; if (q_o[5] !== 4'b0101) begin bad++; $display("FAIL reset_init_q got=%b exp=0101", q_o[5]); end
      total++; if (cnt_o[5] !== 3'd2) begin bad++; $display("FAIL reset_init_cnt got=%0d exp=2", cnt_o[5]); end
      @(negedge CLK);
      RST = 1'b0; IRQ_MASK = '0;
      repeat (2) begin
         tick();
         total++; if (rise_o[5] !== 4'b0000) begin bad++; $display("FAIL release_rise got=%b exp=0000", rise_o[5]); end
         total++; if (q_o[5] !== 4'b0101) begin bad++; $display("FAIL release_q got=%b exp=0101", q_o[5]); end
      end
   endtask

   task automatic test_level();
      do_reset();
      S = 4'b0001;
      tick();
      S = '0;
      tick();
      total++; if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL level_early got=%b exp=0000", q_o[0]); end
      tick();
      total++; if (q_o[0] !== 4'b0001) begin bad++; $display("FAIL level_set got=%b exp=0001", q_o[0]); end
      total++; if (rise_o[0] !== 4'b0001) begin bad++; $display("FAIL level_rise got=%b exp=0001", rise_o[0]); end
      total++; if (cnt_o[0] !== 3'd1) begin bad++; $display("FAIL level_cnt got=%0d exp=1", cnt_o[0]); end
      tick();
      total++; if (rise_o[0] !== 4'b0000) begin bad++; $display("FAIL level_rise_len got=%b exp=0000", rise_o[0]); end
      R = 4'b0001;
      tick();
      R = '0;
      repeat (2) tick();
      total++; if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL level_clr got=%b exp=0000", q_o[0]); end
      total++; if (fall_o[0] !== 4'b0001) begin bad++; $display("FAIL level_fall got=%b exp=0001", fall_o[0]); end
      tick();
      total++; if (fall_o[0] !== 4'b0000) begin bad++; $display("FAIL level_fall_len got=%b exp=0000", fall_o[0]); end
   endtask

   task automatic test_conflict();
      do_reset();
      S = 4'b0101;
      tick();
      S = '0;
      repeat (3) tick();
      S = 4'b1111; R = 4'b1111;
      for (int j = 1; j <= 6; j++) begin
         tick();
         if (j == 4) begin S = '0; R = '0; end
         if (j >= 3) begin
            total++;
            if (q_o[2] !== ((j % 2 == 1) ? 4'b1010 : 4'b0101)) begin
               bad++; $display("FAIL conflict_toggle step=%0d got=%b", j, q_o[2]);
            end
         end
         total++; if (q_o[3] !== 4'b0101) begin bad++; $display("FAIL conflict_hold step=%0d got=%b exp=0101", j, q_o[3]); end
      end
      total++; if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL conflict_rdom got=%b exp=0000", q_o[0]); end
      total++; if (q_o[1] !== 4'b1111) begin bad++; $display("FAIL conflict_sdom got=%b exp=1111", q_o[1]); end
      total++; if (rise_o[2] !== 4'b0101) begin bad++; $display("FAIL conflict_rise got=%b exp=0101", rise_o[2]); end
      total++; if (fall_o[2] !== 4'b1010) begin bad++; $display("FAIL conflict_fall got=%b exp=1010", fall_o[2]); end
   endtask

   task automatic test_edge();
      do_reset();
      S = 4'b0100;
      repeat (3) tick();
      total++; if (q_o[4] !== 4'b0100) begin bad++; $display("FAIL edge_first got=%b exp=0100", q_o[4]); end
      R = 4'b0100;
      tick();
      R = '0;
      repeat (2) tick();
      total++; if (q_o[4] !== 4'b0000) begin bad++; $display("FAIL edge_clr got=%b exp=0000", q_o[4]); end
      for (int j = 0; j < 10; j++) begin
         tick();
         total++; if (q_o[4][2] !== 1'b0) begin bad++; $display("FAIL edge_no_reset step=%0d got=%b exp=0", j, q_o[4][2]); end
      end
      total++; if (q_o[0] !== 4'b0100) begin bad++; $display("FAIL edge_level_ref got=%b exp=0100", q_o[0]); end
      S = '0;
      tick();
      S = 4'b0100;
      repeat (3) tick();
      total++; if (q_o[4] !== 4'b0100) begin bad++; $display("FAIL edge_reset got=%b exp=0100", q_o[4]); end
      total++; if (rise_o[4] !== 4'b0100) begin bad++; $display("FAIL edge_rise got=%b exp=0100", rise_o[4]); end
      S = '0;
   endtask

   task automatic test_irq();
      do_reset();
      IRQ_MASK = 4'b0010; S = 4'b1010;
      tick();
      S = '0;
      repeat (3) tick();
      total++; if (pend_o[0] !== 4'b0010) begin bad++; $display("FAIL irq_pend got=%b exp=0010", pend_o[0]); end
      total++; if (irq_o[0] !== 1'b1) begin bad++; $display("FAIL irq_line got=%b exp=1", irq_o[0]); end
      IRQ_MASK = '0;
      tick();
      total++; if (pend_o[0] !== 4'b0010) begin bad++; $display("FAIL irq_unmask got=%b exp=0010", pend_o[0]); end
      IRQ_ACK = 4'b0001;
      tick();
      IRQ_ACK = '0;
      total++; if (pend_o[0] !== 4'b0010) begin bad++; $display("FAIL irq_ack_idle got=%b exp=0010", pend_o[0]); end
      IRQ_MASK = 4'b0010; R = 4'b0010;
      tick();
      R = '0;
      repeat (2) tick();
      S = 4'b0010;
      tick();
      S = '0;
      repeat (2) tick();
      total++; if (rise_o[0] !== 4'b0010) begin bad++; $display("FAIL irq_new_rise got=%b exp=0010", rise_o[0]); end
      IRQ_ACK = 4'b0010;
      tick();
      IRQ_ACK = '0;
      total++; if (pend_o[0] !== 4'b0010) begin bad++; $display("FAIL irq_set_wins got=%b exp=0010", pend_o[0]); end
      IRQ_ACK = 4'b0010;
      tick();
      IRQ_ACK = '0;
      total++; if (pend_o[0] !== 4'b0000) begin bad++; $display("FAIL irq_ack got=%b exp=0000", pend_o[0]); end
      total++; if (irq_o[0] !== 1'b0) begin bad++; $display("FAIL irq_line_clr got=%b exp=0", irq_o[0]); end
   endtask

   task automatic test_sync();
      int ks [4] = '{5, 6, 0, 7};
      do_reset();
      S = 4'b1000;
      tick();
      S = '0;
      total++; if (q_o[5][3] !== 1'b1) begin bad++; $display("FAIL sync0_set got=%b exp=1", q_o[5][3]); end
      do_reset();
      S = 4'b0010;
      for (int j = 1; j <= 6; j++) begin
         tick();
         S = '0;
         foreach (ks[n]) begin
            total++;
            if (q_o[ks[n]][1] !== ((j >= P_SYNC[ks[n]] + 1) ? 1'b1 : 1'b0)) begin
               bad++; $display("FAIL sync_pulse inst=%0d step=%0d got=%b", ks[n], j, q_o[ks[n]][1]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int rep = 0; rep < 4; rep++) begin
         do_reset();
         for (int c = 0; c < 400; c++) begin
            S        = 4'($urandom) & 4'($urandom);
            R        = 4'($urandom) & 4'($urandom);
            IRQ_MASK = 4'($urandom);
            IRQ_ACK  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tick();
            for (int k = 0; k < N; k++) begin
               total++;
               if ({q_o[k], rise_o[k], fall_o[k]} !== {mq[k], mq[k] & ~mprev[k], ~mq[k] & mprev[k]}) begin
                  bad++; $display("FAIL rnd_q inst=%0d got=%b/%b/%b exp=%b/%b/%b", k, q_o[k], rise_o[k],
                                  fall_o[k], mq[k], mq[k] & ~mprev[k], ~mq[k] & mprev[k]);
               end
               total++;
               if (cnt_o[k] !== 3'($countones(mq[k]))) begin
                  bad++; $display("FAIL rnd_cnt inst=%0d got=%0d exp=%0d", k, cnt_o[k], $countones(mq[k]));
               end
               total++;
               if ({pend_o[k], irq_o[k]} !== {mpend[k], |mpend[k]}) begin
                  bad++; $display("FAIL rnd_irq inst=%0d got=%b/%b exp=%b/%b", k, pend_o[k], irq_o[k],
                                  mpend[k], |mpend[k]);
               end
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_level();
      test_conflict();
      test_edge();
      test_irq();
      test_sync();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
